// File: rtl/counting_down_seg_pkg.sv
// counting_down_seg_pkg: shared state type, seven-segment table and count limit
package counting_down_seg_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [13:0] MAX_COUNT = 14'd9999;
  localparam logic [3:0] BLANK = 4'hF;
  // active-low {dp,g,f,e,d,c,b,a}; entries 10..15 are blank
  localparam logic [15:0][7:0] SEG_LUT = {{6{8'hFF}}, 8'h90, 8'h80, 8'hF8, 8'h82,
                                          8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
endpackage

// File: rtl/counting_down_seg_bin2bcd14.sv
// bin2bcd14: combinational double-dabble, 14-bit binary to four BCD digits
module bin2bcd14 (
  input  logic [13:0] bin,
  output logic [15:0] bcd
);
  always_comb begin
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++)
        bcd[4*j +: 4] = bcd[4*j +: 4] > 4'd4 ? bcd[4*j +: 4] + 4'd3 : bcd[4*j +: 4];
      bcd = {bcd[14:0], bin[i]};
    end
  end
endmodule

// File: rtl/counting_down_seg.sv
// counting_down_seg: loadable seconds countdown with multiplexed 4-digit 7-seg display
// Define COUNTING_DOWN_SEG_BLANK_EN to blank leading-zero digits.
module counting_down_seg
  import counting_down_seg_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 100_000_000,
  parameter int SCAN_DIV       = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] time_in,
  input  logic        start,
  output logic        stop,
  output logic [7:0]  seg,
  output logic [3:0]  an
);
  localparam int PW = CYCLES_PER_SEC > 1 ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP  = PW'(CYCLES_PER_SEC - 1);
  localparam logic [SW-1:0] SCAN_TOP = SW'(SCAN_DIV - 1);
  state_t state, state_n;
  logic [13:0] count, count_n, load;
  logic [PW-1:0] pre, pre_n;
  logic [SW-1:0] scan;
  logic [1:0] idx;
  logic [15:0] bcd;
  logic [3:0] digit;
  logic start_d, trig, zero_d, zero_n, stop_n, blank;
  assign trig = start & ~start_d;
  assign load = time_in > 16'(MAX_COUNT) ? MAX_COUNT : time_in[13:0];
  assign digit = bcd[{idx, 2'b00} +: 4];
`ifdef COUNTING_DOWN_SEG_BLANK_EN
  assign blank = idx != 2'd0 && (bcd >> {idx, 2'b00}) == 16'd0;
`else
  assign blank = 1'b0;
`endif
  bin2bcd14 u_bcd (.bin(count), .bcd(bcd));
  // a zero load is flagged here and turned into stop one cycle later
  always_comb begin
    state_n = state;
    count_n = count;
    pre_n   = pre;
    zero_n  = 1'b0;
    stop_n  = zero_d;
    if (trig) begin
      count_n = load;
      pre_n   = '0;
      state_n = load != 14'd0 ? RUN : IDLE;
      zero_n  = load == 14'd0;
    end else if (state == RUN) begin
      pre_n = pre == PRE_TOP ? '0 : pre + PW'(1);
      if (pre == PRE_TOP) begin
        count_n = count - 14'd1;
        stop_n  = count == 14'd1;
        state_n = count == 14'd1 ? IDLE : RUN;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      pre     <= '0;
      start_d <= 1'b0;
      zero_d  <= 1'b0;
      stop    <= 1'b0;
      scan    <= '0;
      idx     <= '0;
      seg     <= 8'hFF;
      an      <= 4'hF;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pre     <= pre_n;
      start_d <= start;
      zero_d  <= zero_n;
      stop    <= stop_n;
      scan    <= scan == SCAN_TOP ? '0 : scan + SW'(1);
      idx     <= idx + 2'(scan == SCAN_TOP);
      an      <= ~(4'b1 << idx);
      seg     <= SEG_LUT[blank ? BLANK : digit];
    end
  end
endmodule

// File: tb/tb_counting_down_seg.sv
// tb_counting_down_seg: directed and random checks against a timeline reference model
module tb_counting_down_seg;
  localparam int CPS = 10;
  localparam int SD  = 2;
  logic clk = 0, rst = 0, start = 0, stop;
  logic [15:0] time_in = 0;
  logic [7:0] seg;
  logic [3:0] an;
  int checks = 0, failures = 0;
  int e = 0, k = 0, n = 0, r = 0, cm = 0, cm_prev = 0;
  bit act = 0, ps = 0;
  logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int pw [4] = '{1, 10, 100, 1000};
  counting_down_seg #(.CYCLES_PER_SEC(CPS), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .time_in(time_in), .start(start), .stop(stop), .seg(seg), .an(an));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, e);
    end
  endtask
  function automatic logic [7:0] seg_of(int c, int i);
`ifdef COUNTING_DOWN_SEG_BLANK_EN
    if (i > 0 && c < pw[i]) return 8'hFF;
`endif
    return tbl[(c / pw[i]) % 10];
  endfunction
  task automatic step(int cnt);
    logic st_exp;
    logic [3:0] an_exp;
    logic [7:0] seg_exp;
    int i;
    for (int c = 0; c < cnt; c++) begin
      @(posedge clk);
      e++;
      if (!rst) begin
        if (start && !ps) begin
          k = e;
          n = time_in > 9999 ? 9999 : int'(time_in);
          act = 1;
        end
        ps = start;
        r++;
      end
      cm = (rst || !act) ? 0 : (n - (e - k) / CPS > 0 ? n - (e - k) / CPS : 0);
      st_exp = !rst && act && (n > 0 ? e == k + n * CPS : e == k + 1);
      i = r > 0 ? ((r - 1) / SD) % 4 : 0;
      an_exp = r > 0 ? ~(4'b1 << i) : 4'hF;
      seg_exp = r > 0 ? seg_of(cm_prev, i) : 8'hFF;
      cm_prev = cm;
      @(negedge clk);
      chk("stop", {7'd0, stop}, {7'd0, st_exp});
      chk("an", {4'd0, an}, {4'd0, an_exp});
      chk("seg", seg, seg_exp);
    end
  endtask
  task automatic do_reset(int cyc);
    rst = 1;
    #1;
    act = 0; ps = 0; r = 0; cm_prev = 0;
    chk("rst_stop", {7'd0, stop}, 8'd0);
    chk("rst_an", {4'd0, an}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    step(cyc);
    rst = 0;
  endtask
  task automatic pulse(int val, int hold);
    time_in = 16'(val);
    start = 1;
    step(hold);
    start = 0;
  endtask
  initial begin
    #1;
    do_reset(5);
    step(12);
    pulse(1, 2);
    step(15);
    pulse(3, 1);
    step(35);
    pulse(10, 1);
    step(19);
    do_reset(3);
    step(30);
    pulse(9, 1);
    step(24);
    pulse(5, 1);
    step(55);
    pulse(12345, 1);
    step(20);
    pulse(0, 1);
    step(5);
    pulse(42, 1);
    step(16);
    do_reset(2);
    for (int j = 0; j < 8; j++) begin
      int v;
      v = $urandom_range(0, 6);
      pulse(v, $urandom_range(1, 3));
      step($urandom_range(3, (v + 1) * CPS + 3));
    end
    pulse(int'($urandom_range(10000, 65535)), 1);
    step(12);
    do_reset(1);
    step(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counting_down_seg.md
# counting_down_seg

Loadable seconds countdown timer with a multiplexed 4-digit seven-segment driver. The block sits between control logic and the board's LED/7-seg pins. A start request loads a seconds value and counts it down once per second on the display. A one-cycle `stop` pulse is issued when the count reaches zero.

## Interface
- `CYCLES_PER_SEC`, 100_000_000: clock cycles per one-second tick.
- `SCAN_DIV`, 100_000: clock cycles each digit stays enabled during display scan.
- `clk`  in  1  system clock, 100 MHz nominal, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `time_in`  in  16  countdown start value in seconds; sampled on the start edge.
- `start`  in  1  start request; rising-edge detected internally.
- `stop`  out  1  one-cycle pulse when the count reaches 0.
- `seg`  out  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always off.
- `an`  out  4  active-low digit enables, one-hot; an[0] is the units digit.

## Operation
- FSM states:
  - IDLE: count held.
  - RUN: counting.
- Start edge detection: registered `start_d`; an edge is `start & ~start_d`. Holding `start` high does not re-trigger.
- On a start edge, in any state:
  - count ← min(time_in, 9999).
  - Prescaler ← 0.
  - If the loaded value is nonzero, go to RUN.
  - If the loaded value is 0, `stop` pulses on the next cycle and the state stays IDLE.
- In RUN:
  - The prescaler counts 0..CYCLES_PER_SEC-1.
  - At wrap, count decrements by 1.
  - If the decrement produces 0, `stop` pulses for exactly one cycle and the state goes to IDLE.
- A start edge during RUN restarts with the new value. No `stop` is issued for the aborted run.
- Display:
  - The remaining count is converted from binary to 4 BCD digits.
  - The scan counter rotates `an` through 1110, 1101, 1011, 0111, dwelling SCAN_DIV cycles per digit.
  - `seg` carries the active-low pattern of the selected digit.
  - Leading zeros are shown unless the macro below is defined.
- Reset, including mid-countdown:
  - Immediately goes to IDLE with count 0, prescaler 0, scan index 0.
  - Outputs during and at reset: `stop`=0, `seg`=8'hFF, `an`=4'b1111.

## Timing
- A start edge sampled at clock edge k loads the count at edge k.
- For a loaded N>0, `stop` is high during the cycle following edge k + N·CYCLES_PER_SEC, for one cycle.
- For N=0, `stop` is high during the cycle following edge k+1.
- After reset deassertion, the first scan output appears on the first clock edge: `an`=1110, `seg`=digit0 pattern.
- All outputs are registered. `seg` and `an` change together.
- Arithmetic:
  - Count register is 14 bits (max 9999).
  - The decrement never underflows, because RUN always exits at 0.

## Configuration
- `COUNTING_DOWN_SEG_BLANK_EN`:
  - Defined: leading-zero digits are blanked (`seg`=8'hFF while `an` still scans). The units digit is always shown, so count 0 displays "   0".
  - Undefined: all four digits are shown with leading zeros, so count 0 displays "0000".

## Structure
- Shared package `counting_down_seg_pkg`:
  - State enum (IDLE, RUN).
  - 16-entry seven-segment lookup constant for 0–9 plus blank.
  - Constant `MAX_COUNT` = 9999.
- One sub-module, `bin2bcd14`: combinational double-dabble, 14-bit binary to four 4-bit BCD digits.

## Test plan
All scenarios use CYCLES_PER_SEC=10 and SCAN_DIV=2 in simulation.
- Reset: `rst` high for 5 cycles, then low → during reset `stop`=0, `an`=1111, `seg`=FF; after release, `an` scans 1110→1101→1011→0111 with "0000".
- time_in=1, 2-cycle start → `stop` is a single-cycle pulse 10 cycles after the start edge; state returns to IDLE.
- time_in=3 → display walks 0003, 0002, 0001, 0000 at 10-cycle intervals; one `stop` pulse 30 cycles after the start edge.
- Reset mid-run: time_in=10, reset after 20 cycles → no `stop`, display 0000, holding `start` low keeps IDLE.
- Restart and edge cases:
  - Start edge with time_in=5 at count 7 → count reloads to 5; one `stop` only, 50 cycles after the restart edge.
  - time_in=12345 → shows 9999.
  - time_in=0 → `stop` one cycle after the start edge.
- Macro on, count 42 → digits 3 and 2 blank (`seg`=FF), digits 1 and 0 show 4 and 2.
